// File: rtl/darkbus_pkg.sv
// Shared types and defaults for the darkbusmux address-decoding bus multiplexer.
package darkbus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    localparam logic [127:0] DEF_BASE = {32'h4000_0000, 32'h2000_0000, 32'h1000_0000, 32'h0000_0000};
    localparam logic [127:0] DEF_SIZE = {32'hC000_0000, 32'h2000_0000, 32'h1000_0000, 32'h1000_0000};

    localparam int TMO_CW = 16;

endpackage

// File: rtl/darkbusmux_dec.sv
// Combinational region decoder: per-channel hit vector, lowest-index priority select, miss flag.
module darkbusmux_dec #(
    parameter int                   NTGT = 4,
    parameter int                   AW   = 32,
    parameter logic [NTGT*AW-1:0]   BASE = darkbus_pkg::DEF_BASE,
    parameter logic [NTGT*AW-1:0]   SIZE = darkbus_pkg::DEF_SIZE,
    parameter int                   SELW = (NTGT > 1) ? $clog2(NTGT) : 1
) (
    input  logic [AW-1:0]   i_addr,
    output logic [NTGT-1:0] o_hit,
    output logic [SELW-1:0] o_idx,
    output logic            o_miss
);

    always_comb begin
        logic [AW:0] w_lo;
        logic [AW:0] w_hi;
        o_hit = '0;
        w_lo  = '0;
        w_hi  = '0;
        // One extra bit keeps the end of a region that touches the top of memory from wrapping to zero.
        for (int i = 0; i < NTGT; i++) begin
            w_lo     = {1'b0, BASE[i*AW +: AW]};
            w_hi     = w_lo + {1'b0, SIZE[i*AW +: AW]};
            o_hit[i] = ({1'b0, i_addr} >= w_lo) && ({1'b0, i_addr} < w_hi);
        end
        o_idx = '0;
        for (int i = NTGT - 1; i >= 0; i--) begin
            if (o_hit[i]) o_idx = SELW'(i);
        end
        o_miss = ~|o_hit;
    end

endmodule

// File: rtl/darkbusmux.sv
// Single-master to NTGT-target bus multiplexer with registered target side.
// Optional watchdog on the target wait state: define DARKBUSMUX_TIMEOUT_EN.
module darkbusmux
    import darkbus_pkg::*;
#(
    parameter int                   NTGT = 4,
    parameter int                   AW   = 32,
    parameter int                   DW   = 32,
    parameter logic [NTGT*AW-1:0]   BASE = DEF_BASE,
    parameter logic [NTGT*AW-1:0]   SIZE = DEF_SIZE,
    parameter int                   TMO  = 255
) (
    input  logic                XCLK,
    input  logic                XRES,
    input  logic                core_en,
    input  logic                core_rw,
    input  logic [DW/8-1:0]     core_be,
    input  logic [AW-1:0]       core_addr,
    input  logic [DW-1:0]       core_wdata,
    output logic [DW-1:0]       core_rdata,
    output logic                core_valid,
    output logic                core_err,
    output logic [NTGT-1:0]     tgt_en,
    output logic                tgt_rw,
    output logic [DW/8-1:0]     tgt_be,
    output logic [AW-1:0]       tgt_addr,
    output logic [DW-1:0]       tgt_wdata,
    input  logic [NTGT*DW-1:0]  tgt_rdata,
    input  logic [NTGT-1:0]     tgt_valid
);

    localparam int SELW = (NTGT > 1) ? $clog2(NTGT) : 1;

    logic [NTGT-1:0] w_hit;
    logic [NTGT-1:0] w_onehot;
    logic [SELW-1:0] w_sel;
    logic            w_miss;
    logic [AW-1:0]   w_base;

    state_t          r_state;
    logic [SELW-1:0] r_sel;
    logic            r_rw;
    logic [DW/8-1:0] r_be;
    logic [AW-1:0]   r_addr;
    logic [DW-1:0]   r_wdata;
    logic [NTGT-1:0] r_en;
    logic            r_valid;
    logic            r_err;
    logic [DW-1:0]   r_rdata;
`ifdef DARKBUSMUX_TIMEOUT_EN
    logic [TMO_CW-1:0] r_tmo;
`endif

    darkbusmux_dec #(
        .NTGT (NTGT),
        .AW   (AW),
        .BASE (BASE),
        .SIZE (SIZE),
        .SELW (SELW)
    ) u_dec (
        .i_addr (core_addr),
        .o_hit  (w_hit),
        .o_idx  (w_sel),
        .o_miss (w_miss)
    );

    // Isolate the lowest set hit bit so the strobe agrees with the priority index.
    assign w_onehot = w_hit & (~w_hit + NTGT'(1));
    assign w_base   = BASE[w_sel*AW +: AW];

    always_ff @(posedge XCLK or negedge XRES) begin
        if (!XRES) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_rw    <= 1'b0;
            r_be    <= '0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_en    <= '0;
            r_valid <= 1'b0;
            r_err   <= 1'b0;
            r_rdata <= '0;
`ifdef DARKBUSMUX_TIMEOUT_EN
            r_tmo   <= '0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (core_en) begin
                        r_rw    <= core_rw;
                        r_be    <= core_be;
                        r_wdata <= core_wdata;
                        r_sel   <= w_sel;
                        if (w_miss) begin
                            r_valid <= 1'b1;
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                            r_state <= ST_RESP;
                        end else begin
                            r_addr  <= core_addr - w_base;
                            r_en    <= w_onehot;
                            r_state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE, ST_WAIT: begin
                    r_en <= '0;
                    if (tgt_valid[r_sel]) begin
                        r_valid <= 1'b1;
                        r_err   <= 1'b0;
                        r_rdata <= r_rw ? '0 : tgt_rdata[r_sel*DW +: DW];
                        r_state <= ST_RESP;
                    end
`ifdef DARKBUSMUX_TIMEOUT_EN
                    else if (r_state == ST_ISSUE) begin
                        r_tmo   <= '0;
                        r_state <= ST_WAIT;
                    end else if (r_tmo == TMO_CW'(TMO - 1)) begin
                        r_valid <= 1'b1;
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                        r_state <= ST_RESP;
                    end else begin
                        r_tmo <= r_tmo + TMO_CW'(1);
                    end
`else
                    else begin
                        r_state <= ST_WAIT;
                    end
`endif
                end
                ST_RESP: begin
                    r_valid <= 1'b0;
                    r_err   <= 1'b0;
                    r_rdata <= '0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign core_rdata = r_rdata;
    assign core_valid = r_valid;
    assign core_err   = r_err;
    assign tgt_en     = r_en;
    assign tgt_rw     = r_rw;
    assign tgt_be     = r_be;
    assign tgt_addr   = r_addr;
    assign tgt_wdata  = r_wdata;

endmodule
